// File: rtl/axi4_lite_bram_bridge.sv
// rtl/axi4_lite_bram_bridge.sv - AXI4-Lite slave onto NUM_BANKS single-port BRAM banks
module axi4_lite_bram_bridge #(
  parameter int DWIDTH               = 32,
  parameter int AWIDTH               = 4,
  parameter int MEM_DEPTH            = 10,
  parameter int NUM_BANKS            = 2,
  parameter int RD_LATENCY           = 1,
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 8
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  output logic [AWIDTH-1:0]                   o_bram_addr,
  output logic [DWIDTH-1:0]                   o_bram_d,
  output logic [DWIDTH/8-1:0]                 o_bram_be,
  output logic [NUM_BANKS-1:0]                o_bram_ce,
  output logic [NUM_BANKS-1:0]                o_bram_we,
  input  logic [NUM_BANKS*DWIDTH-1:0]         i_bram_q,
  output logic                                o_busy
);

  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH+1)'(MEM_DEPTH);
  localparam logic [BW:0]     BANKS_L = (BW+1)'(NUM_BANKS);

  typedef enum logic [2:0] {IDLE, WR_ACC, WR_RESP, RD_ACC, RD_WAIT, RD_RESP} state_t;

  state_t              state;
  logic                prio_wr;
  logic [1:0]          rd_cnt;
  logic [BW-1:0]       rd_bank;
  logic [AWIDTH-1:0]   aw_off, ar_off;
  logic [BW-1:0]       aw_bank, ar_bank;
  logic [NUM_BANKS-1:0] aw_onehot, ar_onehot;
  logic                aw_ok, ar_ok;
  logic [DWIDTH-1:0]   q_arr [NUM_BANKS];
  logic                wr_req, rd_req;
  logic                unused_bits;

  assign aw_off = s00_axi_awaddr[2 +: AWIDTH];
  assign ar_off = s00_axi_araddr[2 +: AWIDTH];

  // With a single bank there are no bank-select bits at all.
  if (NUM_BANKS > 1) begin : g_bank_sel
    assign aw_bank = s00_axi_awaddr[2+AWIDTH +: BW];
    assign ar_bank = s00_axi_araddr[2+AWIDTH +: BW];
  end else begin : g_bank_one
    assign aw_bank = '0;
    assign ar_bank = '0;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_q
    assign q_arr[b] = i_bram_q[b*DWIDTH +: DWIDTH];
  end

  assign aw_ok = ({1'b0, aw_off} < DEPTH_L) && ({1'b0, aw_bank} < BANKS_L);
  assign ar_ok = ({1'b0, ar_off} < DEPTH_L) && ({1'b0, ar_bank} < BANKS_L);

  always_comb begin
    aw_onehot = '0;
    ar_onehot = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      aw_onehot[b] = (aw_bank == BW'(b));
      ar_onehot[b] = (ar_bank == BW'(b));
    end
  end

  assign wr_req = s00_axi_awvalid & s00_axi_wvalid;
  assign rd_req = s00_axi_arvalid;
  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state           <= IDLE;
      prio_wr         <= 1'b1;
      rd_cnt          <= '0;
      rd_bank         <= '0;
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_bresp   <= 2'b00;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rresp   <= 2'b00;
      s00_axi_rdata   <= '0;
      o_bram_addr     <= '0;
      o_bram_d        <= '0;
      o_bram_be       <= '0;
      o_bram_ce       <= '0;
      o_bram_we       <= '0;
      o_busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // On a collision the priority flag flips so the other type wins next time.
          if (wr_req && (!rd_req || prio_wr)) begin
            state           <= WR_ACC;
            s00_axi_awready <= 1'b1;
            s00_axi_wready  <= 1'b1;
            o_busy          <= 1'b1;
            if (rd_req) prio_wr <= 1'b0;
          end else if (rd_req) begin
            state           <= RD_ACC;
            s00_axi_arready <= 1'b1;
            o_busy          <= 1'b1;
            if (wr_req) prio_wr <= 1'b1;
          end
        end
        WR_ACC: begin
          s00_axi_awready <= 1'b0;
          s00_axi_wready  <= 1'b0;
          o_bram_addr     <= aw_off;
          o_bram_d        <= s00_axi_wdata;
          o_bram_be       <= s00_axi_wstrb;
          s00_axi_bvalid  <= 1'b1;
          state           <= WR_RESP;
          if (aw_ok) begin
            o_bram_ce     <= aw_onehot;
            o_bram_we     <= aw_onehot;
            s00_axi_bresp <= 2'b00;
          end else begin
            s00_axi_bresp <= 2'b10;
          end
        end
        WR_RESP: begin
          o_bram_ce <= '0;
          o_bram_we <= '0;
          if (s00_axi_bready) begin
            s00_axi_bvalid <= 1'b0;
            o_busy         <= 1'b0;
            state          <= IDLE;
          end
        end
        RD_ACC: begin
          s00_axi_arready <= 1'b0;
          if (ar_ok) begin
            o_bram_addr <= ar_off;
            o_bram_ce   <= ar_onehot;
            rd_bank     <= ar_bank;
            rd_cnt      <= '0;
            state       <= RD_WAIT;
          end else begin
            s00_axi_rdata  <= '0;
            s00_axi_rresp  <= 2'b10;
            s00_axi_rvalid <= 1'b1;
            state          <= RD_RESP;
          end
        end
        RD_WAIT: begin
          o_bram_ce <= '0;
          if (rd_cnt == 2'(RD_LATENCY)) begin
            s00_axi_rdata  <= q_arr[rd_bank];
            s00_axi_rresp  <= 2'b00;
            s00_axi_rvalid <= 1'b1;
            state          <= RD_RESP;
          end else begin
            rd_cnt <= rd_cnt + 2'd1;
          end
        end
        RD_RESP: begin
          if (s00_axi_rready) begin
            s00_axi_rvalid <= 1'b0;
            o_busy         <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi4_lite_bram_bridge.md
Name: axi4_lite_bram_bridge

Overview:
AXI4-Lite slave that maps a byte-addressed register window onto NUM_BANKS independent single-port BRAM banks. The banks are tetromino, board and score tables, each MEM_DEPTH words deep. This block is the generalised successor of the single-bank AXI-to-BRAM path. It adds:
- multi-bank decode
- byte-strobe writes
- configurable BRAM read latency
- SLVERR on out-of-range access
- round-robin read/write arbitration

It sits between the PS AXI interconnect and the game-logic BRAMs, driving each bank's AXI-side port.

Parameters:
DWIDTH, 32, BRAM word width; must equal C_S00_AXI_DATA_WIDTH
AWIDTH, 4, per-bank word-address width
MEM_DEPTH, 10, valid words per bank (1..2^AWIDTH)
NUM_BANKS, 2, number of BRAM banks (1..8)
RD_LATENCY, 1, BRAM clock cycles from ce to valid q (1..3)
C_S00_AXI_DATA_WIDTH, 32, AXI data width
C_S00_AXI_ADDR_WIDTH, 8, AXI byte-address width; must be >= 2+AWIDTH+clog2(NUM_BANKS)

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  reset, asynchronous, active-low
s00_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready  -  standard AXI4-Lite write channels, C_S00_AXI_* widths; awprot ignored
s00_axi_araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready  -  standard AXI4-Lite read channels; arprot ignored
o_bram_addr  out  AWIDTH  shared word address to all banks
o_bram_d  out  DWIDTH  shared write data
o_bram_be  out  DWIDTH/8  shared byte enables (copy of wstrb)
o_bram_ce  out  NUM_BANKS  one-hot chip enable
o_bram_we  out  NUM_BANKS  one-hot write enable
i_bram_q  in  NUM_BANKS*DWIDTH  read data; bank b occupies [b*DWIDTH +: DWIDTH]
o_busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Address decode on the latched byte address A:
  - offset = A[2 +: AWIDTH]; bank = A[2+AWIDTH +: clog2(NUM_BANKS)]
  - A[1:0] and upper bits are ignored
  - Out of range when offset >= MEM_DEPTH or bank >= NUM_BANKS
- Reset (async assert, sync release):
  - State IDLE, priority flag = write.
  - All ready/valid, ce, we and busy outputs are 0.
  - addr, d, be, rdata, bresp and rresp are 0.
  - A transaction in flight is dropped with no response.
- FSM states: IDLE, WR_ACC, WR_RESP, RD_ACC, RD_WAIT, RD_RESP.
- IDLE, sampled each edge:
  - Write request = awvalid & wvalid (both required); read request = arvalid.
  - Only one request: go to WR_ACC or RD_ACC.
  - Both requests: grant per priority flag, then toggle the flag, so a later collision serves the other type first.
- WR_ACC:
  - awready = wready = 1 for exactly one cycle (registered).
  - At that edge latch awaddr, wdata and wstrb.
  - Next cycle, if in range: o_bram_ce[bank] = o_bram_we[bank] = 1 for one cycle, with addr/d/be valid. bresp = 2'b00.
  - If out of range: no ce/we, bresp = 2'b10.
  - bvalid rises in that same cycle → WR_RESP.
- WR_RESP: hold bvalid and bresp until bvalid & bready; bvalid drops next cycle → IDLE.
- RD_ACC:
  - arready = 1 for one cycle; latch araddr.
  - If in range: next cycle o_bram_ce[bank] = 1, we = 0 → RD_WAIT.
  - If out of range: rdata = 0, rresp = 2'b10, rvalid rises next cycle → RD_RESP.
- RD_WAIT:
  - Counter counts RD_LATENCY cycles after the ce cycle.
  - On the last count, capture i_bram_q of the latched bank into rdata, rresp = 2'b00 → RD_RESP with rvalid = 1.
- RD_RESP: hold rvalid, rdata and rresp until rvalid & rready → IDLE.
- Read timing with arvalid sampled at edge k:
  - arready high in cycle k+1; ce in cycle k+2; rvalid from cycle k+3+RD_LATENCY.
  - Example: RD_LATENCY = 1 gives rvalid at k+4.
- Write timing with awvalid & wvalid sampled at edge k: ready high in cycle k+1; ce/we and bvalid in cycle k+2.
- Concurrency: only one outstanding transaction. No ready is asserted outside the ACC states, so requests arriving while busy wait.
- Port hygiene: ce and we are never asserted in more than one bit. Output data is unchanged while valid is held under backpressure.

Test Plan:
1. Write 0xDEADBEEF to 0x0C (bank 0, offset 3), wstrb 0xF → ce[0]=we[0]=1, addr=3, bresp=00. Read 0x0C → rdata 0xDEADBEEF, rresp 00, rvalid exactly 3 cycles after the arready cycle (RD_LATENCY=1).
2. Write 0x12345678 to 0x48 (bank 1, offset 2) → only ce[1]/we[1] pulse. Read 0x08 (bank 0, offset 2) returns bank-0 contents unaffected.
3. Full write 0xFFFFFFFF to 0x04, then partial write 0x000000AA with wstrb 0x1 → o_bram_be=0x1. Read back gives 0xFFFFFFAA.
4. Write to 0x28 (offset 10 ≥ MEM_DEPTH) → no ce/we, bresp=2'b10. Read 0x3C → rdata 0, rresp=2'b10, rvalid one cycle after the arready cycle.
5. Assert aw/w and ar together twice, with bready and rready held low for 5 cycles each time:
   - First collision: write served first. Second collision: read served first.
   - bvalid/bresp and rvalid/rdata stay stable throughout the stall.
6. Deassert aresetn during RD_WAIT → all outputs 0 asynchronously, FSM IDLE. After release, a new read completes normally with RD_LATENCY=3 (rvalid at k+6).
